// File: rtl/fp_mult_sched.sv
// Round-robin scheduler sharing one pipelined FP32 multiplier among NUM_REQ requesters.
// Define FPM_EXC_FLAGS_EN to carry multiplier overflow/underflow flags with each response.
module fp_mult_sched #(
    parameter int NUM_REQ    = 4,
    parameter int MULT_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [31:0]             mult_a,
    output logic [31:0]             mult_b,
    input  logic [31:0]             mult_result,
`ifdef FPM_EXC_FLAGS_EN
    input  logic                    mult_ovf,
    input  logic                    mult_uf,
    output logic                    resp_ovf,
    output logic                    resp_uf,
`endif
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FPM_EXC_FLAGS_EN
    localparam int EW = ID_W + 34;
`else
    localparam int EW = ID_W + 32;
`endif

    logic [ID_W-1:0] rr_ptr;
    logic            tag_v  [MULT_LAT];
    logic [ID_W-1:0] tag_id [MULT_LAT];
    logic [EW-1:0]   mem    [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   fifo_count, inflight;
    logic [EW-1:0]   hold_q, head, wr_entry;
    logic            credit_ok, grant_found, issue, push, pop;
    logic [ID_W-1:0] grant_id;
    int              idx;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MULT_LAT; i++) inflight = inflight + CW'(tag_v[i]);
    end

    // Credits count both buffered and in-flight results, so a push never meets a full FIFO.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign issue     = grant_found && credit_ok && !rst;
    assign req_ready = issue ? (NUM_REQ'(1) << grant_id) : '0;
    assign mult_a    = issue ? req_a[32*grant_id +: 32] : '0;
    assign mult_b    = issue ? req_b[32*grant_id +: 32] : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= issue ? grant_id : '0;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            if (issue) rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
        end
    end

    assign push       = tag_v[MULT_LAT-1];
    assign resp_valid = (fifo_count != '0);
    assign pop        = resp_valid && resp_ready;

`ifdef FPM_EXC_FLAGS_EN
    assign wr_entry = {mult_ovf, mult_uf, tag_id[MULT_LAT-1], mult_result};
`else
    assign wr_entry = {tag_id[MULT_LAT-1], mult_result};
`endif

    // NOTE: the storage array is not reset; its contents are only visible through count-qualified reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            hold_q     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= head;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // When empty, the last popped entry stays on the response port.
    assign head      = resp_valid ? mem[rd_ptr] : hold_q;
    assign resp_data = head[31:0];
    assign resp_id   = head[32 +: ID_W];
`ifdef FPM_EXC_FLAGS_EN
    assign resp_ovf  = head[EW-1];
    assign resp_uf   = head[EW-2];
`endif

    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count == CW'(FIFO_DEPTH)));

endmodule
